program_store: RTL

Instruction source sitting directly upstream of the 8-bit datapath. It accepts a program as a byte stream over a valid/ready handshake and stores it in an on-chip word memory. It then releases the datapath to run, and presents the instruction addressed by the datapath's `PC` on every rising edge of the datapath's divided clock `CLK_`. Addresses past the loaded program return a fixed fill word.

---
 rtl/program_store.sv | 127 ++++++++++++
 1 files changed

// File: rtl/program_store.sv
// Instruction store for the 8-bit datapath: byte-stream loader, word memory,
// and a registered instruction fetch that fires on each rising edge of CLK_.
module program_store #(
  parameter int         DEPTH = 64,
  parameter logic [7:0] FILL  = 8'h00
) (
  input  logic       _CLK,
  input  logic       RESET_N,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic       start,
  input  logic       abort,
  input  logic       CLK_,
  input  logic [7:0] PC,
  output logic [7:0] instruction,
  output logic       run,
  output logic [7:0] prog_len,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, READY, RUN} state_t;

  state_t     state_q;
  logic [7:0] wr_ptr_q;
  logic       clk_dly_q;
  logic [7:0] instr_q;
  logic       run_q;
  logic [7:0] prog_len_q;
  logic       ovf_q;

  logic [7:0] mem_q [DEPTH];

  logic       accept;
  logic       clk_rise;
  logic       wr_en;
  logic       last_slot;
  logic [7:0] rd_word;

  assign load_ready = (state_q == IDLE) || (state_q == LOAD);
  assign accept     = load_valid & load_ready;
  assign clk_rise   = CLK_ & ~clk_dly_q;
  // An abort in LOAD swallows the byte offered on the same edge.
  assign wr_en      = accept & RESET_N & ~(abort & (state_q == LOAD));
  assign last_slot  = (wr_ptr_q == 8'(DEPTH - 1));
  assign rd_word    = (PC < prog_len_q) ? mem_q[PC[AW-1:0]] : FILL;

  assign instruction = instr_q;
  assign run         = run_q;
  assign prog_len    = prog_len_q;
  assign overflow    = ovf_q;

  always_ff @(posedge _CLK) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= load_data;
  end

  always_ff @(posedge _CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      wr_ptr_q   <= 8'd0;
      clk_dly_q  <= 1'b0;
      instr_q    <= FILL;
      run_q      <= 1'b0;
      prog_len_q <= 8'd0;
      ovf_q      <= 1'b0;
    end else begin
      clk_dly_q <= CLK_;
      case (state_q)
        IDLE: begin
          if (accept) begin
            ovf_q      <= 1'b0;
            wr_ptr_q   <= 8'd1;
            prog_len_q <= 8'd1;
            state_q    <= load_last ? READY : LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            state_q    <= IDLE;
            wr_ptr_q   <= 8'd0;
            prog_len_q <= 8'd0;
            instr_q    <= FILL;
            run_q      <= 1'b0;
          end else if (accept) begin
            wr_ptr_q   <= wr_ptr_q + 8'd1;
            prog_len_q <= wr_ptr_q + 8'd1;
            if (load_last) begin
              state_q <= READY;
            end else if (last_slot) begin
              state_q <= READY;
              ovf_q   <= 1'b1;
            end
          end
        end
        READY: begin
          if (abort) begin
            state_q    <= IDLE;
            wr_ptr_q   <= 8'd0;
            prog_len_q <= 8'd0;
            instr_q    <= FILL;
            run_q      <= 1'b0;
          end else if (start) begin
            state_q <= RUN;
            run_q   <= 1'b1;
            instr_q <= mem_q[0];
          end
        end
        RUN: begin
          if (abort) begin
            state_q    <= IDLE;
            wr_ptr_q   <= 8'd0;
            prog_len_q <= 8'd0;
            instr_q    <= FILL;
            run_q      <= 1'b0;
          end else if (clk_rise) begin
            instr_q <= rd_word;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
